// File: rtl/fifo_drain_arbiter_if.sv
// Read-side bus of the multi-FIFO bank: per-FIFO empty/data/pop plus the merged output stream.
// master = arbiter side, slave = FIFO bank / downstream consumer side.
interface fifo_drain_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_FIFOS  = 4
);
  localparam int unsigned IDW = $clog2(NUM_FIFOS);

  logic [NUM_FIFOS-1:0]            fifo_empty;
  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_dout;
  logic [NUM_FIFOS-1:0]            fifo_rd_en;
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [IDW-1:0]                  out_id;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_rd_en, out_valid, out_data, out_id
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_id
  );
endinterface

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain scheduler with bounded bursts for the multi-FIFO bank.
// Define FIFO_ARB_STRICT_PRIO_EN for fixed lowest-index-first priority instead.
module fifo_drain_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_FIFOS  = 4,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned IDW = $clog2(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  fifo_drain_arbiter_if.master bus,
  output logic                 busy
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e         state_q;
  logic [IDW-1:0] own_q;
  logic [IDW-1:0] last_q;
  logic [BW-1:0]  bcnt_q;
  logic [IDW-1:0] sel;
  logic           found;
  logic           slot_free;
  logic           load;

  assign found     = ~&bus.fifo_empty;
  assign slot_free = !bus.out_valid || bus.out_ready;
  // rst_n gate keeps the pop strobes quiet while reset is held
  assign load      = rst_n && enable && slot_free && found;

`ifdef FIFO_ARB_STRICT_PRIO_EN
  always_comb begin
    sel = '0;
    for (int i = int'(NUM_FIFOS) - 1; i >= 0; i--) begin
      if (!bus.fifo_empty[i]) sel = IDW'(i);
    end
  end

  assign busy = bus.out_valid;
`else
  int base;
  int start;
  int idx;

  // Descending scan so the nearest non-empty FIFO after the start point wins.
  always_comb begin
    sel   = '0;
    base  = (state_q == StBurst) ? int'(own_q) : int'(last_q);
    start = (base + 1 >= int'(NUM_FIFOS)) ? 0 : base + 1;
    idx   = 0;
    for (int k = int'(NUM_FIFOS) - 1; k >= 0; k--) begin
      idx = start + k;
      if (idx >= int'(NUM_FIFOS)) idx = idx - int'(NUM_FIFOS);
      if (!bus.fifo_empty[idx]) sel = IDW'(idx);
    end
    if (state_q == StBurst && !bus.fifo_empty[own_q] && bcnt_q < BW'(MAX_BURST)) begin
      sel = own_q;
    end
  end

  assign busy = (state_q == StBurst);
`endif

  always_comb begin
    bus.fifo_rd_en = '0;
    if (load) bus.fifo_rd_en[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      own_q         <= '0;
      last_q        <= '0;
      bcnt_q        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_id    <= '0;
    end else begin
      if (load) begin
        bus.out_data  <= bus.fifo_dout[sel*DATA_WIDTH +: DATA_WIDTH];
        bus.out_id    <= sel;
        bus.out_valid <= 1'b1;
      end else if (slot_free) begin
        bus.out_valid <= 1'b0;
      end

      if (!enable) begin
        state_q <= StIdle;
        if (state_q == StBurst) last_q <= own_q;
      end else if (load) begin
        state_q <= StBurst;
        own_q   <= sel;
        // A new grant, or a re-grant of the sole requester after a full burst, restarts the count
        if (state_q == StIdle || sel != own_q || bcnt_q >= BW'(MAX_BURST)) begin
          bcnt_q <= BW'(1);
        end else begin
          bcnt_q <= bcnt_q + 1'b1;
        end
      end else if (state_q == StBurst && !found) begin
        state_q <= StIdle;
        last_q  <= own_q;
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter: behavioural FIFO bank, per-FIFO order scoreboard.
module tb_fifo_drain_arbiter;
  localparam int DW = 8;
  localparam int NF = 4;
  localparam int MB = 4;
  localparam int D  = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic busy;

  always #5 clk = ~clk;

  fifo_drain_arbiter_if #(.DATA_WIDTH(DW), .NUM_FIFOS(NF)) bus ();

  fifo_drain_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_FIFOS (NF),
    .MAX_BURST (MB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .bus   (bus),
    .busy  (busy)
  );

  // Show-ahead FIFO bank model; words are {fifo index, sequence number}.
  logic [DW-1:0] mem [NF][D];
  int wr_ptr [NF] = '{0, 0, 0, 0};
  int rd_ptr [NF] = '{0, 0, 0, 0};
  int rx_seq [NF] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < NF; i++) begin
      if (bus.fifo_rd_en[i]) rd_ptr[i] <= rd_ptr[i] + 1;
    end
  end

  always_comb begin
    bus.fifo_empty = '0;
    bus.fifo_dout  = '0;
    for (int i = 0; i < NF; i++) begin
      bus.fifo_empty[i]          = (wr_ptr[i] == rd_ptr[i]);
      bus.fifo_dout[i*DW +: DW]  = mem[i][rd_ptr[i] % D];
    end
  end

  int checks   = 0;
  int failures = 0;
  logic [NF-1:0] rd_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int f, input int n);
    for (int k = 0; k < n; k++) begin
      mem[f][wr_ptr[f] % D] = {f[1:0], 6'(wr_ptr[f])};
      wr_ptr[f]++;
    end
  endtask

  // Called at posedge+1 after inputs are driven: samples this cycle, returns at next posedge+1.
  task automatic tick();
    logic [DW-1:0] e;
    logic          bad;
    #1;
    rd_seen = bus.fifo_rd_en;
    bad = ((rd_seen & bus.fifo_empty) != '0) || !$onehot0(rd_seen);
    check("rd_legal", 32'(bad), 0);
    if (bus.out_valid && bus.out_ready) begin
      e = {bus.out_id, 6'(rx_seq[bus.out_id])};
      check("sb_word", 32'(bus.out_data), 32'(e));
      rx_seq[bus.out_id]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (!bus.out_valid && (&bus.fifo_empty)) done = 1'b1;
    end
    check(tag, 32'(done), 1);
  endtask

  task automatic check_counts(input string tag);
    for (int i = 0; i < NF; i++) check(tag, rx_seq[i], wr_ptr[i]);
  endtask

  initial begin
    int            base1;
    logic [DW-1:0] held;

    // Reset with FIFO 2 loaded and enable high: no pops may leak out.
    rst_n         = 1'b0;
    enable        = 1'b1;
    bus.out_ready = 1'b0;
    push(2, 3);
    #2;
    check("rst_rd_en", 32'(bus.fifo_rd_en), 0);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_data", 32'(bus.out_data), 0);
    check("rst_id", 32'(bus.out_id), 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    check("rst_rd_en_edge", 32'(bus.fifo_rd_en), 0);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;

    // Single source: three back-to-back pops of FIFO 2.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t1_rd", 32'(rd_seen), 4);
      check("t1_valid", 32'(bus.out_valid), 1);
      check("t1_id", 32'(bus.out_id), 2);
      check("t1_data", 32'(bus.out_data), 32'h80 + k);
      check("t1_busy", 32'(busy), 1);
    end
    tick();
    check("t1_rd_done", 32'(rd_seen), 0);
    check("t1_valid_done", 32'(bus.out_valid), 0);
    check("t1_busy_done", 32'(busy), 0);

`ifndef FIFO_ARB_STRICT_PRIO_EN
    // All four loaded after a fresh reset: bursts of 4 starting at FIFO 1, no gaps.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int f = 0; f < NF; f++) push(f, 10);
    for (int k = 0; k < 40; k++) begin
      int e;
      e = (k < 32) ? (((k / 4) % 4) + 1) % 4 : (((k - 32) / 2) + 1) % 4;
      tick();
      check("t2_rd", 32'(rd_seen), 1 << e);
      check("t2_valid", 32'(bus.out_valid), 1);
      check("t2_id", 32'(bus.out_id), e);
    end
    tick();
    check("t2_valid_done", 32'(bus.out_valid), 0);
    check_counts("t2_count");
`endif

    // Backpressure: the held word and id stay put, no pops while stalled.
    base1 = wr_ptr[1];
    push(1, 6);
    push(3, 6);
    tick();
    tick();
    bus.out_ready = 1'b0;
    held = {2'd1, 6'(base1 + 1)};
    check("t3_held_id", 32'(bus.out_id), 1);
    check("t3_held_data", 32'(bus.out_data), 32'(held));
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_stall_rd", 32'(rd_seen), 0);
      check("t3_stall_valid", 32'(bus.out_valid), 1);
      check("t3_stall_id", 32'(bus.out_id), 1);
      check("t3_stall_data", 32'(bus.out_data), 32'(held));
    end
    bus.out_ready = 1'b1;
    drain("t3_drain");
    check_counts("t3_count");

    // Sole requester beyond MAX_BURST: 9 pops with no bubble.
    push(0, 9);
    for (int k = 0; k < 9; k++) begin
      tick();
      check("t4_rd", 32'(rd_seen), 1);
      check("t4_valid", 32'(bus.out_valid), 1);
      check("t4_id", 32'(bus.out_id), 0);
    end
    tick();
    check("t4_rd_done", 32'(rd_seen), 0);
    check("t4_valid_done", 32'(bus.out_valid), 0);
    check_counts("t4_count");

    // enable dropped with a stalled word: word held, then no pops until enable returns.
    bus.out_ready = 1'b0;
    push(2, 3);
    tick();
    check("t5_rd", 32'(rd_seen), 4);
    check("t5_valid", 32'(bus.out_valid), 1);
    held = bus.out_data;
    enable = 1'b0;
    tick();
    check("t5_off_rd", 32'(rd_seen), 0);
    check("t5_off_valid", 32'(bus.out_valid), 1);
    check("t5_off_data", 32'(bus.out_data), 32'(held));
`ifdef FIFO_ARB_STRICT_PRIO_EN
    check("t5_off_busy", 32'(busy), 1);
`else
    check("t5_off_busy", 32'(busy), 0);
`endif
    tick();
    check("t5_off_rd2", 32'(rd_seen), 0);
    check("t5_off_valid2", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    tick();
    check("t5_accept_rd", 32'(rd_seen), 0);
    check("t5_accept_valid", 32'(bus.out_valid), 0);
    tick();
    check("t5_idle_rd", 32'(rd_seen), 0);
    check("t5_idle_valid", 32'(bus.out_valid), 0);
    enable = 1'b1;
    tick();
    check("t5_on_rd", 32'(rd_seen), 4);
    check("t5_on_valid", 32'(bus.out_valid), 1);
    drain("t5_drain");
    check_counts("t5_count");

`ifndef FIFO_ARB_STRICT_PRIO_EN
    // Reset mid-burst on FIFO 0; after release the search restarts at index 1.
    push(0, 3);
    push(2, 6);
    tick();
    check("t6_rd0", 32'(rd_seen), 1);
    tick();
    check("t6_rd1", 32'(rd_seen), 1);
    check("t6_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.out_valid), 0);
    check("t6_rst_data", 32'(bus.out_data), 0);
    check("t6_rst_id", 32'(bus.out_id), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_rd", 32'(bus.fifo_rd_en), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NF; i++) rx_seq[i] = rd_ptr[i];
    tick();
    check("t6_first_grant", 32'(rd_seen), 4);
    drain("t6_drain");
    check_counts("t6_count");
`else
    // Fixed priority: FIFO 0 drains completely before FIFO 3.
    push(3, 3);
    push(0, 4);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("sp_rd0", 32'(rd_seen), 1);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      check("sp_rd3", 32'(rd_seen), 8);
    end
    drain("sp_drain");
    check_counts("sp_count");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
